pal_cfg_loader: RTL and testbench



---
 rtl/pal_cfg_loader.sv | 186 ++++++++++++++++++
 tb/tb_pal_cfg_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: byte-stream feeder for the PAL configuration shift chain.
// Accepts NUM_BYTES config bytes over a valid/ready interface, serialises each
// byte LSB-first onto CFG_OUT with a CFG_SHIFT strobe, then consumes one XOR
// checksum trailer byte and reports DONE / CHK_OK.
//
// Ports:
//   CLK        clock
//   RES        synchronous active-high reset
//   START      one-cycle pulse, begins or restarts a load
//   DIN        config / checksum byte
//   DIN_VALID  DIN holds a byte
//   DIN_READY  loader accepts DIN this cycle (combinational from state)
//   CFG_OUT    serial config bit to the PAL CFG input
//   CFG_SHIFT  CFG_OUT is a valid bit for the chain to shift in
//   BUSY       load in progress (WAIT, SHIFT or CHECK)
//   DONE       checksum byte consumed, load finished
//   CHK_OK     checksum matched; meaningful only with DONE=1
//   BYTE_CNT   config bytes accepted since last START
module pal_cfg_loader #(
  parameter  int unsigned CFG_BITS  = 192,
  localparam int unsigned NUM_BYTES = CFG_BITS / 8,
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             START,
  input  logic [7:0]       DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             CFG_OUT,
  output logic             CFG_SHIFT,
  output logic             BUSY,
  output logic             DONE,
  output logic             CHK_OK,
  output logic [CNT_W-1:0] BYTE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [7:0]         shreg, shreg_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         acc, acc_d;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_d;
  logic               cfg_out_q, cfg_out_d;
  logic               cfg_shift_q, cfg_shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               chk_ok_q, chk_ok_d;
  logic               more_bytes;
  logic               xfer;

  // More config bytes still expected before the checksum trailer.
  assign more_bytes = (byte_cnt < CNT_W'(NUM_BYTES));

  // Ready depends only on state, bit index and byte count, never on DIN_VALID.
  always_comb begin
    DIN_READY = 1'b0;
    case (state)
      S_WAIT:  DIN_READY = 1'b1;
      S_CHECK: DIN_READY = 1'b1;
      S_SHIFT: DIN_READY = (bit_idx == 3'd7) && more_bytes;
      default: DIN_READY = 1'b0;
    endcase
  end

  assign xfer = DIN_VALID && DIN_READY;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_idx_d   = bit_idx;
    acc_d       = acc;
    byte_cnt_d  = byte_cnt;
    cfg_out_d   = 1'b0;
    cfg_shift_d = 1'b0;
    done_d      = done_q;
    chk_ok_d    = chk_ok_q;

    if (START) begin
      // Restart discards any coinciding transfer and any partial byte.
      state_d    = S_WAIT;
      bit_idx_d  = 3'd0;
      acc_d      = 8'd0;
      byte_cnt_d = '0;
      done_d     = 1'b0;
      chk_ok_d   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_d = S_IDLE;
        end

        S_WAIT: begin
          if (xfer) begin
            state_d     = S_SHIFT;
            shreg_d     = DIN;
            acc_d       = acc ^ DIN;
            byte_cnt_d  = byte_cnt + CNT_W'(1);
            bit_idx_d   = 3'd0;
            cfg_out_d   = DIN[0];
            cfg_shift_d = 1'b1;
          end
        end

        S_SHIFT: begin
          if (bit_idx != 3'd7) begin
            bit_idx_d   = bit_idx + 3'd1;
            cfg_out_d   = shreg[bit_idx + 3'd1];
            cfg_shift_d = 1'b1;
          end else if (xfer) begin
            // Gapless reload: bit 0 of the new byte follows bit 7 directly.
            shreg_d     = DIN;
            acc_d       = acc ^ DIN;
            byte_cnt_d  = byte_cnt + CNT_W'(1);
            bit_idx_d   = 3'd0;
            cfg_out_d   = DIN[0];
            cfg_shift_d = 1'b1;
          end else begin
            state_d = more_bytes ? S_WAIT : S_CHECK;
          end
        end

        S_CHECK: begin
          if (xfer) begin
            chk_ok_d = (DIN == acc);
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_SHIFT) || (state_d == S_CHECK);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state       <= S_IDLE;
      shreg       <= 8'd0;
      bit_idx     <= 3'd0;
      acc         <= 8'd0;
      byte_cnt    <= '0;
      cfg_out_q   <= 1'b0;
      cfg_shift_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_ok_q    <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      bit_idx     <= bit_idx_d;
      acc         <= acc_d;
      byte_cnt    <= byte_cnt_d;
      cfg_out_q   <= cfg_out_d;
      cfg_shift_q <= cfg_shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chk_ok_q    <= chk_ok_d;
    end
  end

  assign CFG_OUT   = cfg_out_q;
  assign CFG_SHIFT = cfg_shift_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CHK_OK    = chk_ok_q;
  assign BYTE_CNT  = byte_cnt;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader with default CFG_BITS=192.
module tb_pal_cfg_loader;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'd0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic       CFG_OUT;
  logic       CFG_SHIFT;
  logic       BUSY;
  logic       DONE;
  logic       CHK_OK;
  logic [4:0] BYTE_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pal_cfg_loader dut (
    .CLK       (CLK),
    .RES       (RES),
    .START     (START),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .CFG_OUT   (CFG_OUT),
    .CFG_SHIFT (CFG_SHIFT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CHK_OK    (CHK_OK),
    .BYTE_CNT  (BYTE_CNT)
  );

  typedef struct {
    logic       res;
    logic       start;
    logic       valid;
    logic [7:0] din;
    logic       e_ready;
    logic       e_shift;
    logic       e_out;
    logic       e_busy;
    logic       e_done;
    logic [4:0] e_cnt;
  } vec_t;

  typedef struct {
    int         mode;     // 0: bytes 0x01..0x18, 1: 0xA5 repeated
    logic [7:0] trailer;
    int         max_gap;
    logic       exp_ok;
  } scn_t;

  vec_t vecs[14];
  scn_t scns[4];

  function automatic vec_t mkv(input logic res, input logic start, input logic valid,
                               input logic [7:0] din, input logic rdy, input logic sh,
                               input logic o, input logic busy, input logic done,
                               input logic [4:0] cnt);
    vec_t v;
    v.res = res; v.start = start; v.valid = valid; v.din = din;
    v.e_ready = rdy; v.e_shift = sh; v.e_out = o; v.e_busy = busy;
    v.e_done = done; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    DIN_VALID = 1'b0;
    step();
    START = 1'b0;
  endtask

  // Present bytes 0x01, 0x02, ... back to back until n transfers complete.
  task automatic feed_n(input int n);
    int   x = 0;
    int   cyc = 0;
    logic xfer;
    while (x < n && cyc < 500) begin
      DIN_VALID = 1'b1;
      DIN = 8'(x + 1);
      xfer = DIN_READY;
      step();
      cyc++;
      if (xfer) x++;
    end
    DIN_VALID = 1'b0;
    check("feed_timeout", 32'(x), 32'(n));
  endtask

  task automatic run_load(input scn_t s);
    logic [7:0] data[25];
    int   idx = 0;
    int   gap = 0;
    int   cyc = 0;
    int   nshift = 0;
    int   first = -1;
    int   last = -1;
    int   bad = 0;
    logic xfer;
    logic ebit;
    for (int i = 0; i < 24; i++) data[i] = (s.mode == 0) ? 8'(i + 1) : 8'hA5;
    data[24] = s.trailer;

    pulse_start();
    check("start_cnt", 32'(BYTE_CNT), 0);
    check("start_ready", 32'(DIN_READY), 1);

    while (!DONE && cyc < 3000) begin
      if (gap > 0) begin
        DIN_VALID = 1'b0;
        gap--;
      end else begin
        DIN_VALID = 1'b1;
        DIN = data[(idx > 24) ? 24 : idx];
      end
      xfer = DIN_VALID && DIN_READY;
      step();
      cyc++;
      if (xfer) begin
        idx++;
        gap = (s.max_gap > 0) ? int'($urandom_range(s.max_gap, 0)) : 0;
      end
      if (CFG_SHIFT) begin
        if (nshift < 192) begin
          ebit = data[nshift / 8][nshift % 8];
          if (CFG_OUT !== ebit) bad++;
        end
        if (first < 0) first = cyc;
        last = cyc;
        nshift++;
      end else if (CFG_OUT !== 1'b0) begin
        bad++;
      end
    end
    DIN_VALID = 1'b0;

    check("load_timeout", 32'(DONE), 1);
    check("shift_count", 32'(nshift), 192);
    check("bit_errors", 32'(bad), 0);
    check("load_cnt", 32'(BYTE_CNT), 24);
    check("load_chk_ok", 32'(CHK_OK), 32'(s.exp_ok));
    check("load_busy", 32'(BUSY), 0);
    check("load_ready", 32'(DIN_READY), 0);
    if (s.max_gap == 0) check("contiguous", 32'(last - first + 1), 192);

    // Bytes offered in DONE must be ignored.
    if (!s.exp_ok) begin
      DIN_VALID = 1'b1;
      DIN = 8'h18;
      for (int k = 0; k < 3; k++) begin
        step();
        check("done_ready", 32'(DIN_READY), 0);
      end
      DIN_VALID = 1'b0;
      check("done_hold", 32'(DONE), 1);
      check("done_chk", 32'(CHK_OK), 0);
      check("done_cnt", 32'(BYTE_CNT), 24);
    end
  endtask

  initial begin
    // Reset, start and first byte (0x03 -> 1,1,0,0,0,0,0,0), cycle by cycle.
    vecs[0]  = mkv(1, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 1, 8'h55, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mkv(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    vecs[5]  = mkv(0, 0, 1, 8'h03, 0, 1, 1, 1, 0, 1);
    vecs[6]  = mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
    vecs[7]  = mkv(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    vecs[8]  = mkv(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    vecs[9]  = mkv(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    vecs[10] = mkv(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    vecs[11] = mkv(0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    vecs[12] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 1);
    vecs[13] = mkv(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1);

    scns[0] = '{mode: 0, trailer: 8'h18, max_gap: 0, exp_ok: 1'b1};
    scns[1] = '{mode: 0, trailer: 8'h19, max_gap: 0, exp_ok: 1'b0};
    scns[2] = '{mode: 0, trailer: 8'h18, max_gap: 5, exp_ok: 1'b1};
    scns[3] = '{mode: 1, trailer: 8'h00, max_gap: 3, exp_ok: 1'b1};

    for (int i = 0; i < 14; i++) begin
      RES = vecs[i].res;
      START = vecs[i].start;
      DIN_VALID = vecs[i].valid;
      DIN = vecs[i].din;
      step();
      check($sformatf("vec%0d_ready", i), 32'(DIN_READY), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_shift", i), 32'(CFG_SHIFT), 32'(vecs[i].e_shift));
      check($sformatf("vec%0d_out", i),   32'(CFG_OUT),   32'(vecs[i].e_out));
      check($sformatf("vec%0d_busy", i),  32'(BUSY),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i),  32'(DONE),      32'(vecs[i].e_done));
      check($sformatf("vec%0d_chk", i),   32'(CHK_OK),    0);
      check($sformatf("vec%0d_cnt", i),   32'(BYTE_CNT),  32'(vecs[i].e_cnt));
    end
    START = 1'b0;
    DIN_VALID = 1'b0;

    for (int i = 0; i < 3; i++) run_load(scns[i]);

    // Restart mid-SHIFT: 11th byte (0x0B) at bit 3, then START.
    pulse_start();
    feed_n(11);
    for (int k = 0; k < 3; k++) step();
    check("rs_bit3_shift", 32'(CFG_SHIFT), 1);
    check("rs_bit3_out", 32'(CFG_OUT), 1);
    check("rs_bit3_cnt", 32'(BYTE_CNT), 11);
    START = 1'b1;
    DIN_VALID = 1'b1;
    DIN = 8'h77;
    step();
    check("rs_shift", 32'(CFG_SHIFT), 0);
    check("rs_cnt", 32'(BYTE_CNT), 0);
    check("rs_ready", 32'(DIN_READY), 1);
    check("rs_busy", 32'(BUSY), 1);
    // START with a coinciding transfer in WAIT: the byte is discarded.
    step();
    START = 1'b0;
    DIN_VALID = 1'b0;
    check("rs_xfer_cnt", 32'(BYTE_CNT), 0);
    check("rs_xfer_shift", 32'(CFG_SHIFT), 0);
    check("rs_xfer_ready", 32'(DIN_READY), 1);

    run_load(scns[3]);

    // Reset at byte 5 bit 6.
    pulse_start();
    feed_n(5);
    for (int k = 0; k < 6; k++) step();
    check("rm_bit6_shift", 32'(CFG_SHIFT), 1);
    check("rm_bit6_cnt", 32'(BYTE_CNT), 5);
    RES = 1'b1;
    DIN_VALID = 1'b1;
    step();
    RES = 1'b0;
    check("rm_ready", 32'(DIN_READY), 0);
    check("rm_shift", 32'(CFG_SHIFT), 0);
    check("rm_out", 32'(CFG_OUT), 0);
    check("rm_busy", 32'(BUSY), 0);
    check("rm_done", 32'(DONE), 0);
    check("rm_chk", 32'(CHK_OK), 0);
    check("rm_cnt", 32'(BYTE_CNT), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rm_idle_ready", 32'(DIN_READY), 0);
      check("rm_idle_cnt", 32'(BYTE_CNT), 0);
    end
    DIN_VALID = 1'b0;
    pulse_start();
    check("rm_start_ready", 32'(DIN_READY), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
